rcu_gp_server: RTL and testbench
================================

Name: rcu_gp_server

Overview:
- Hardware grace-period engine for the RCU mechanism, serving the updater side.
- Readers report read-side critical-section entry/exit; the block keeps two-phase per-reader counters.
- An updater requests synchronize and gets an acknowledge only after every reader that entered before the request has exited.
- Sits between the reader ports and one update client; it implements the flip/drain/flip/drain protocol in hardware.

Parameters:
- NRDR, 4, number of reader ports.
- DEPTHW, 3, width of the per-reader nesting depth; maximum nesting is 2^DEPTHW-1.
- SELMSB, 2, MSB of the scan index; requires 2^(SELMSB+1) > NRDR.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- rd_lock  in  NRDR  per-reader critical-section entry strobe
- rd_unlock  in  NRDR  per-reader critical-section exit strobe
- sync_req  in  1  updater synchronize request; level, held until ack
- sync_ack  out  1  one-cycle grace-period-complete pulse
- busy  out  1  high while the FSM is not IDLE
- flip  out  1  current global phase
- rd_err  out  NRDR  sticky per-reader protocol error
- gp_count  out  8  completed grace periods (optional feature)

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (reset_n=0 at an edge) clears: flip, all counters, depths and phases, state=IDLE, scan index cpunum=0, sync_ack, rd_err, gp_count. busy=0.
- Reset mid-grace-period abandons the request with no ack.
- Per reader r, depth[r] counts nesting; lphase[r] is the latched phase; ctr[r][0..1] are nonzero flags per phase.
- Lock with depth=0: lphase<=flip, ctr[r][flip]<=1, depth<=1.
- Lock with depth>0: depth+1.
- Unlock: depth-1. On reaching 0, ctr[r][lphase]<=0.
- Lock and unlock in the same cycle with depth>=1: no change.
- Lock and unlock in the same cycle with depth=0: treated as lock then unlock; net state unchanged, no error.
- Unlock at depth 0: ignored, rd_err[r]<=1.
- Lock at maximum depth: ignored, rd_err[r]<=1.
- rd_err bits clear only on reset.
- FSM states: IDLE, DRAIN0, FLIP, DRAIN1, ACK.
  - IDLE: on sync_req=1, cpunum<=0, go to DRAIN0.
  - DRAIN0: scans one reader per cycle. If ctr[cpunum][~flip]==0, then cpunum+1; otherwise stall on the same index. After index NRDR-1 passes, go to FLIP.
  - FLIP: flip<=~flip, cpunum<=0, go to DRAIN1.
  - DRAIN1: same scan as DRAIN0 with the new flip. Then go to ACK.
  - ACK: sync_ack=1 for exactly this cycle, gp_count+1 (wraps 255->0), go to IDLE.
- sync_req sampled low in ACK or later: no new request is started.
- A request still high in the cycle after ACK starts a new grace period (back-to-back).
- Minimum latency from sync_req to sync_ack is 2*NRDR+3 cycles with no readers active.
- Lock changes applied in the same cycle as the FLIP edge latch the old flip value; the updated counter is visible to the next scan.
- Safety invariant: when sync_ack=1, no reader has depth>0 with lphase equal to the phase held at request time.

Optional Feature:
- Macro RCU_GP_COUNT_EN.
- Defined: gp_count is an 8-bit wrapping count of completed grace periods.
- Undefined: no counter register is built; gp_count is tied to 0.

Decomposition:
- Package rcu_pkg holds the FSM state typedef (IDLE..ACK) and constants for the default NRDR and DEPTHW.
- Sub-module rcu_reader_slot is instantiated NRDR times. Each instance holds depth, lphase, the ctr pair and rd_err, and exports ctr[0..1].
- The top level holds the FSM, flip, cpunum and gp_count.

Test Plan:
- Idle sync, no readers: pulse sync_req at cycle 0 -> sync_ack at cycle 11 (NRDR=4), flip=1, gp_count=1.
- Reader 2 locks before the request and unlocks at cycle 20 -> DRAIN1 stalls on cpunum=2 (DRAIN0 passes, since the reader's phase is the current one). sync_ack occurs a few cycles after cycle 20, never earlier.
- Reader 1 locks after FLIP (lphase=1) and stays locked -> sync_ack is still issued; the new reader does not block the current grace period.
- Reader 0 locks 3 times, unlocks twice -> its counter stays nonzero. Third unlock clears it. A fourth unlock sets rd_err[0]=1 and leaves depth=0.
- Reader 3 locks 7 times, then locks an 8th time with DEPTHW=3 -> rd_err[3]=1 and depth stays 7.
- Assert reset_n=0 during DRAIN1 -> next cycle state=IDLE, flip=0, no sync_ack, all counters 0.

Source files
------------

// File: rtl/rcu_pkg.sv
// rcu_pkg: shared FSM state type and default sizing for the RCU grace-period engine.
package rcu_pkg;

    localparam int NRDR_DEF   = 4;
    localparam int DEPTHW_DEF = 3;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN0,
        FLIP,
        DRAIN1,
        ACK
    } state_t;

endpackage

// File: rtl/rcu_reader_slot.sv
// rcu_reader_slot: one reader's nesting depth, latched phase, per-phase busy flags and sticky error.
module rcu_reader_slot import rcu_pkg::*; #(
    parameter int DEPTHW = DEPTHW_DEF
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       lock,
    input  logic       unlock,
    input  logic       flip,
    output logic [1:0] ctr,
    output logic       err
);

    localparam logic [DEPTHW-1:0] DMAX = '1;

    logic [DEPTHW-1:0] depth;
    logic              lphase;

    // Simultaneous lock and unlock cancel at any depth, so only one-sided strobes act.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            depth  <= '0;
            lphase <= 1'b0;
            ctr    <= '0;
            err    <= 1'b0;
        end else if (lock && !unlock) begin
            if (depth == DMAX) begin
                err <= 1'b1;
            end else begin
                depth <= depth + DEPTHW'(1);
                if (depth == '0) begin
                    lphase   <= flip;
                    ctr[flip] <= 1'b1;
                end
            end
        end else if (unlock && !lock) begin
            if (depth == '0) begin
                err <= 1'b1;
            end else begin
                depth <= depth - DEPTHW'(1);
                if (depth == DEPTHW'(1)) ctr[lphase] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rcu_gp_server.sv
// rcu_gp_server: flip/drain/flip/drain grace-period engine serving one updater over NRDR readers.
// Define RCU_GP_COUNT_EN to build the wrapping completed-grace-period counter on gp_count.
module rcu_gp_server import rcu_pkg::*; #(
    parameter int NRDR   = NRDR_DEF,
    parameter int DEPTHW = DEPTHW_DEF,
    parameter int SELMSB = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [NRDR-1:0] rd_lock,
    input  logic [NRDR-1:0] rd_unlock,
    input  logic            sync_req,
    output logic            sync_ack,
    output logic            busy,
    output logic            flip,
    output logic [NRDR-1:0] rd_err,
    output logic [7:0]      gp_count
);

    localparam int SW = SELMSB + 1;
    localparam int PW = 1 << SW;

    state_t          state;
    logic [SW-1:0]   cpunum;
    logic [NRDR-1:0] c0;
    logic [NRDR-1:0] c1;
    logic [PW-1:0]   pend;

    for (genvar i = 0; i < NRDR; i++) begin : g_slot
        logic [1:0] c;
        rcu_reader_slot #(.DEPTHW(DEPTHW)) u_slot (
            .clock  (clock),
            .reset_n(reset_n),
            .lock   (rd_lock[i]),
            .unlock (rd_unlock[i]),
            .flip   (flip),
            .ctr    (c),
            .err    (rd_err[i])
        );
        assign c0[i] = c[0];
        assign c1[i] = c[1];
    end

    // Readers still holding the phase that is not current; padded so cpunum indexes it exactly.
    assign pend = PW'(flip ? c0 : c1);
    assign busy = state != IDLE;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            flip     <= 1'b0;
            cpunum   <= '0;
            sync_ack <= 1'b0;
        end else begin
            sync_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync_req) begin
                        cpunum <= '0;
                        state  <= DRAIN0;
                    end
                end
                DRAIN0, DRAIN1: begin
                    if (!pend[cpunum]) begin
                        cpunum <= cpunum + SW'(1);
                        if (cpunum == SW'(NRDR - 1)) state <= state == DRAIN0 ? FLIP : ACK;
                    end
                end
                FLIP: begin
                    flip   <= ~flip;
                    cpunum <= '0;
                    state  <= DRAIN1;
                end
                ACK: begin
                    sync_ack <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RCU_GP_COUNT_EN
    always_ff @(posedge clock) begin
        if (!reset_n) gp_count <= '0;
        else if (state == ACK) gp_count <= gp_count + 8'd1;
    end
`else
    assign gp_count = '0;
`endif

endmodule

// File: tb/tb_rcu_gp_server.sv
// tb_rcu_gp_server: directed and randomized checks of rcu_gp_server against a reader-set safety model.
module tb_rcu_gp_server;

    localparam int NRDR = 4;
    localparam int DEPTHW = 3;
    localparam int DMAX = 7;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            sync_req = 1'b0;
    logic [NRDR-1:0] rd_lock = '0;
    logic [NRDR-1:0] rd_unlock = '0;
    logic            sync_ack;
    logic            busy;
    logic            flip;
    logic [NRDR-1:0] rd_err;
    logic [7:0]      gp_count;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_cyc = 0;
    int mgp = 0;
    int mdepth [NRDR];
    logic [NRDR-1:0] merr = '0;
    logic [NRDR-1:0] waited = '0;
    bit gp_active = 0;
    int n;

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    rcu_gp_server #(.NRDR(NRDR), .DEPTHW(DEPTHW), .SELMSB(2)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .rd_lock  (rd_lock),
        .rd_unlock(rd_unlock),
        .sync_req (sync_req),
        .sync_ack (sync_ack),
        .busy     (busy),
        .flip     (flip),
        .rd_err   (rd_err),
        .gp_count (gp_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Readers in a critical section when a grace period starts must each reach depth 0 before its ack.
    task automatic model_edge();
        if (!reset_n) begin
            for (int r = 0; r < NRDR; r++) mdepth[r] = 0;
            merr = '0;
            waited = '0;
            gp_active = 0;
            mgp = 0;
        end else begin
            for (int r = 0; r < NRDR; r++) begin
                if (rd_lock[r] && !rd_unlock[r]) begin
                    if (mdepth[r] == DMAX) merr[r] = 1'b1;
                    else mdepth[r]++;
                end else if (rd_unlock[r] && !rd_lock[r]) begin
                    if (mdepth[r] == 0) merr[r] = 1'b1;
                    else mdepth[r]--;
                end
                if (mdepth[r] == 0) waited[r] = 1'b0;
            end
            if (!gp_active && sync_req) begin
                gp_active = 1;
                start_cyc = cyc;
                for (int r = 0; r < NRDR; r++) waited[r] = mdepth[r] > 0;
            end
        end
    endtask

    task automatic compare();
        logic [31:0] exp_cnt;
        if (!reset_n) check("rst_flip", flip, 0);
        if (sync_ack) begin
            check("ack_req", gp_active, 1);
            check("safety", waited, 0);
            mgp++;
            check("ack_flip", flip, mgp % 2);
            check("ack_busy", busy, 0);
            gp_active = 0;
        end else begin
            check("busy", busy, gp_active);
        end
        check("rd_err", rd_err, merr);
`ifdef RCU_GP_COUNT_EN
        exp_cnt = mgp % 256;
`else
        exp_cnt = 0;
`endif
        check("gp_count", gp_count, exp_cnt);
        if (gp_active) check("gp_timeout", (cyc - start_cyc) < 2000, 1);
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        cyc++;
        compare();
    endtask

    task automatic strobe(input int r, input bit lk);
        if (lk) rd_lock[r] = 1'b1;
        else rd_unlock[r] = 1'b1;
        tick();
        rd_lock = '0;
        rd_unlock = '0;
    endtask

    task automatic wait_ack(input int lim, output int got);
        got = 0;
        for (int k = 1; k <= lim && got == 0; k++) begin
            tick();
            if (sync_ack) got = k;
        end
    endtask

    initial begin
        for (int r = 0; r < NRDR; r++) mdepth[r] = 0;
        @(negedge clock);
        repeat (2) tick();
        check("rst_busy", busy, 0);
        check("rst_ack", sync_ack, 0);
        check("rst_err", rd_err, 0);
        check("rst_cnt", gp_count, 0);
        reset_n = 1'b1;
        tick();

        // idle grace period, then a back-to-back one from a held request
        sync_req = 1'b1;
        wait_ack(30, n);
        check("lat_idle", n, 11);
        check("flip_gp1", flip, 1);
        wait_ack(30, n);
        check("lat_b2b", n, 11);
        sync_req = 1'b0;
        check("flip_gp2", flip, 0);
        tick();

        // pre-existing reader 2 stalls DRAIN1 until it unlocks
        strobe(2, 1);
        sync_req = 1'b1;
        n = 0;
        for (int k = 1; k <= 40 && n == 0; k++) begin
            if (k == 21) rd_unlock[2] = 1'b1;
            tick();
            rd_unlock = '0;
            if (sync_ack) n = k;
        end
        sync_req = 1'b0;
        check("lat_stall", n, 24);

        // reader 1 entering after FLIP does not block
        sync_req = 1'b1;
        n = 0;
        for (int k = 1; k <= 30 && n == 0; k++) begin
            if (k == 7) rd_lock[1] = 1'b1;
            tick();
            rd_lock = '0;
            if (sync_ack) n = k;
        end
        sync_req = 1'b0;
        check("lat_newrdr", n, 11);
        tick();
        strobe(1, 0);

        // nesting on reader 0 and unlock underflow
        repeat (3) strobe(0, 1);
        repeat (2) strobe(0, 0);
        sync_req = 1'b1;
        wait_ack(20, n);
        check("nest_hold", n, 0);
        strobe(0, 0);
        wait_ack(10, n);
        check("nest_release", n > 0, 1);
        sync_req = 1'b0;
        strobe(0, 0);
        check("err0", rd_err[0], 1);
        check("err_only0", rd_err, 1);

        // maximum depth on reader 3
        repeat (7) strobe(3, 1);
        check("err3_pre", rd_err[3], 0);
        strobe(3, 1);
        check("err3_max", rd_err[3], 1);
        repeat (6) strobe(3, 0);
        sync_req = 1'b1;
        wait_ack(15, n);
        check("max_hold", n, 0);
        strobe(3, 0);
        wait_ack(10, n);
        check("max_release", n > 0, 1);
        sync_req = 1'b0;
        tick();
        sync_req = 1'b1;
        wait_ack(30, n);
        check("lat_clean", n, 11);
        sync_req = 1'b0;
        tick();

        // reset while stalled in DRAIN1
        strobe(2, 1);
        sync_req = 1'b1;
        repeat (8) tick();
        check("busy_d1", busy, 1);
        reset_n = 1'b0;
        sync_req = 1'b0;
        tick();
        check("rst2_busy", busy, 0);
        check("rst2_ack", sync_ack, 0);
        check("rst2_err", rd_err, 0);
        check("rst2_cnt", gp_count, 0);
        reset_n = 1'b1;
        wait_ack(15, n);
        check("rst2_noack", n, 0);
        sync_req = 1'b1;
        wait_ack(30, n);
        check("lat_post_rst", n, 11);
        sync_req = 1'b0;
        tick();

        // randomized readers and requests
        for (int i = 0; i < 3000; i++) begin
            for (int r = 0; r < NRDR; r++) begin
                int x;
                x = $urandom_range(0, 99);
                rd_lock[r] = x < 30 || x >= 95;
                rd_unlock[r] = (x >= 30 && x < 65) || x >= 95;
            end
            if (!sync_req && $urandom_range(0, 7) == 0) sync_req = 1'b1;
            tick();
            if (sync_ack && $urandom_range(0, 1) == 1) sync_req = 1'b0;
        end
        rd_lock = '0;
        for (int k = 0; k < 12; k++) begin
            for (int r = 0; r < NRDR; r++) rd_unlock[r] = mdepth[r] > 0;
            tick();
        end
        rd_unlock = '0;
        if (gp_active) begin
            wait_ack(60, n);
            check("final_ack", n > 0, 1);
        end
        sync_req = 1'b0;
        tick();
        check("gp_progress", mgp > 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
